uart_to_fifo: RTL
=================

// Module: uart_to_fifo
// PURPOSE
//  Receive-side bridge: takes bytes from the UART RX core and pushes them into the
//  input FIFO feeding the convolution datapath. UART RX cannot be stalled, so a
//  2-entry skid queue absorbs short FIFO-full periods. Overruns are flagged and
//  counted. A frame counter pulses once every FRAME_LEN bytes written.
// PARAMETERS
//  FRAME_LEN  1024  bytes per image frame; frame_done pulses on each multiple, >=1
//  CNT_W      16    width of drop_count and frame_count, must hold FRAME_LEN-1
// PORTS
//  clk           in   1      system clock; all state on posedge
//  rstn          in   1      asynchronous active-low reset
//  uart_data     in   8      received byte, valid only with uart_valid
//  uart_valid    in   1      1-cycle strobe per received byte; no backpressure
//  fifo_din      out  8      byte to FIFO (queue head)
//  fifo_wr_en    out  1      FIFO write strobe (combinational)
//  fifo_full     in   1      FIFO full; no write taken while high
//  clear         in   1      sync clear of queue, overflow, counters
//  overflow      out  1      sticky: at least one byte dropped since reset/clear
//  drop_count    out  CNT_W  dropped bytes, saturates at all-ones
//  frame_count   out  CNT_W  bytes written in current frame, 0..FRAME_LEN-1
//  frame_done    out  1      1-cycle pulse after the FRAME_LEN-th write of a frame
// BEHAVIOUR
//  Reset (rstn low, async): queue empty, fifo_din=0, fifo_wr_en=0, overflow=0,
//   drop_count=0, frame_count=0, frame_done=0. Reset mid-frame discards queue.
//  Queue: 2-entry FIFO of registers, head/tail pointers plus occupancy 0..2.
//   States by occupancy: EMPTY(0), ONE(1), TWO(2).
//  fifo_wr_en = (occupancy!=0) && !fifo_full; fifo_din = head entry (0 when EMPTY).
//  Per posedge, pop = fifo_wr_en, push = uart_valid:
//   - push only: byte enqueued at tail, occ+1.
//   - pop only: head advances, occ-1.
//   - push+pop: both; occ unchanged (legal in ONE and TWO).
//   - push while TWO and no pop: byte dropped, queue unchanged, overflow<=1,
//     drop_count+1 unless saturated.
//   - push while TWO and pop: accepted (no drop).
//  Latency: byte strobed at edge N is written at edge N+1 if queue was empty
//   and fifo_full low; order of bytes strictly preserved.
//  Framing: each pop increments frame_count; on pop with frame_count==FRAME_LEN-1,
//   frame_count<=0 and frame_done<=1 for exactly one cycle; else frame_done<=0.
//   FRAME_LEN==1: frame_done high on every cycle following a write.
//  clear (sync, priority over everything except rstn): queue emptied, overflow,
//   drop_count, frame_count, frame_done to 0; a uart_valid in the same cycle is
//   discarded and not counted as a drop; fifo_wr_en still reflects pre-clear
//   queue that cycle (that write counts to FIFO but not to frame_count).
//  fifo_full toggling: write taken only in cycles where fifo_full is low at edge.
//  Overflow and drop_count only change on drop or clear/reset.
// TESTING
//  1. Reset, fifo_full=0, send 0x11,0x22,0x33 spaced 10 cycles -> each written
//     1 cycle after its strobe, frame_count=3, overflow=0.
//  2. fifo_full=1, strobe 0xA1,0xA2,0xA3 -> queue TWO, 0xA3 dropped, overflow=1,
//     drop_count=1; release full -> FIFO gets 0xA1,0xA2 on consecutive cycles.
//  3. Queue TWO, fifo_full=0, strobe 0xB0 same cycle as pop -> no drop, order
//     preserved, drop_count unchanged.
//  4. FRAME_LEN=4, write 9 bytes -> frame_done pulses after 4th and 8th writes,
//     frame_count=1 at end.
//  5. Force 0xFFFF+3 drops with CNT_W=16 -> drop_count holds 0xFFFF; clear -> all
//     counters/flags 0, queue empty, concurrent strobe discarded.
//  6. Assert rstn low mid-frame with queue TWO -> outputs zero immediately
//     (asynchronously); after release, first new byte written with frame_count=1.

Source files
------------

// File: rtl/uart_to_fifo.sv
// uart_to_fifo
//   Receive-side bridge from the UART RX core into the convolution input FIFO.
//   The UART cannot be stalled, so a 2-entry skid queue soaks up short FIFO-full
//   periods. Bytes arriving while the queue is full and not draining are dropped,
//   flagged (sticky overflow) and counted (saturating drop_count). frame_count
//   tracks bytes written in the current frame and frame_done pulses one cycle
//   after every FRAME_LEN-th write.
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   uart_data/valid    received byte and its 1-cycle strobe (no backpressure)
//   fifo_din/wr_en     queue head and write strobe towards the FIFO
//   fifo_full          FIFO full; no write is taken while high
//   clear              synchronous clear of queue, flags and counters
//   overflow           sticky drop flag
//   drop_count         saturating count of dropped bytes
//   frame_count        bytes written in the current frame, 0..FRAME_LEN-1
//   frame_done         1-cycle pulse after the last write of a frame
module uart_to_fifo #(
    parameter int FRAME_LEN = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [7:0]       uart_data,
    input  logic             uart_valid,
    output logic [7:0]       fifo_din,
    output logic             fifo_wr_en,
    input  logic             fifo_full,
    input  logic             clear,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] frame_count,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    occ_e       occ_r;
    occ_e       occ_next_s;
    logic [7:0] mem_r [2];
    logic       head_r;
    logic       tail_r;
    logic       pop_s;
    logic       push_s;
    logic       drop_s;

    // FIFO-facing outputs: head of the queue, write whenever something is queued
    always_comb begin
        fifo_wr_en = 1'b0;
        fifo_din   = 8'h00;
        if (occ_r != EMPTY) begin
            fifo_wr_en = !fifo_full;
            fifo_din   = mem_r[head_r];
        end else begin
            fifo_wr_en = 1'b0;
            fifo_din   = 8'h00;
        end
    end

    // Occupancy next-state; a push into a full queue only survives if the head pops
    always_comb begin
        pop_s      = fifo_wr_en;
        push_s     = uart_valid;
        drop_s     = 1'b0;
        occ_next_s = occ_r;
        case (occ_r)
            EMPTY: begin
                if (push_s) occ_next_s = ONE;
                else        occ_next_s = EMPTY;
            end
            ONE: begin
                if (push_s && !pop_s)      occ_next_s = TWO;
                else if (!push_s && pop_s) occ_next_s = EMPTY;
                else                       occ_next_s = ONE;
            end
            TWO: begin
                if (pop_s && !push_s) occ_next_s = ONE;
                else                  occ_next_s = TWO;
                drop_s = push_s && !pop_s;
            end
            default: begin
                occ_next_s = EMPTY;
            end
        endcase
    end

    // Occupancy state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ_r <= EMPTY;
        end else if (clear) begin
            occ_r <= EMPTY;
        end else begin
            occ_r <= occ_next_s;
        end
    end

    // Queue storage and pointers; a push+pop in TWO overwrites the slot being read out
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_r   <= 1'b0;
            tail_r   <= 1'b0;
            mem_r[0] <= 8'h00;
            mem_r[1] <= 8'h00;
        end else if (clear) begin
            head_r <= 1'b0;
            tail_r <= 1'b0;
        end else begin
            if (pop_s) begin
                head_r <= ~head_r;
            end
            if (push_s && !drop_s) begin
                mem_r[tail_r] <= uart_data;
                tail_r        <= ~tail_r;
            end
        end
    end

    // Overflow flag, saturating drop counter and frame counter/pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow    <= 1'b0;
            drop_count  <= {CNT_W{1'b0}};
            frame_count <= {CNT_W{1'b0}};
            frame_done  <= 1'b0;
        end else if (clear) begin
            overflow    <= 1'b0;
            drop_count  <= {CNT_W{1'b0}};
            frame_count <= {CNT_W{1'b0}};
            frame_done  <= 1'b0;
        end else begin
            if (drop_s) begin
                overflow <= 1'b1;
                if (drop_count != CNT_MAX) begin
                    drop_count <= drop_count + CNT_ONE;
                end
            end
            if (pop_s) begin
                if (frame_count == FRAME_LAST) begin
                    frame_count <= {CNT_W{1'b0}};
                    frame_done  <= 1'b1;
                end else begin
                    frame_count <= frame_count + CNT_ONE;
                    frame_done  <= 1'b0;
                end
            end else begin
                frame_done <= 1'b0;
            end
        end
    end

endmodule
